// File: rtl/rv32i_pkg.sv
// ---------------------------------------------------------------------------
// rv32i_pkg : opcode constants and decode-stage state encoding shared by the
//             decode controller and its hazard detector.        Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package rv32i_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OPIMM  = 7'b0010011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    HAZARD = 2'd2,
    FLUSH  = 2'd3
  } decode_state_t;

endpackage

`default_nettype wire

// File: rtl/hazard_detect.sv
// ---------------------------------------------------------------------------
// hazard_detect : source-register usage by opcode and load-use hazard check
//                 against the load currently in execute.          Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hazard_detect
  import rv32i_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        ex_is_load,
  input  logic [4:0]  ex_rd,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        hazard
);

  logic [6:0] opcode;
  logic [4:0] rs1;
  logic [4:0] rs2;
  logic       unused_instr_bits;

  assign opcode = instr[6:0];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];

  // funct/rd/immediate bits play no part in hazard detection
  assign unused_instr_bits = ^{instr[31:25], instr[14:7]};

  always_comb begin
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    case (opcode)
      OP_OP, OP_STORE, OP_BRANCH: begin
        uses_rs1 = 1'b1;
        uses_rs2 = 1'b1;
      end
      OP_OPIMM, OP_LOAD, OP_JALR: begin
        uses_rs1 = 1'b1;
      end
      default: begin
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
      end
    endcase
  end

  // x0 is hardwired zero, so a load targeting it never creates a dependency
  assign hazard = ex_is_load && (ex_rd != 5'd0) &&
                  ((uses_rs1 && (rs1 == ex_rd)) || (uses_rs2 && (rs2 == ex_rd)));

endmodule

`default_nettype wire

// File: rtl/decode_controller.sv
// ---------------------------------------------------------------------------
// decode_controller : decode-stage control FSM (issue, load-use stall,
//                     branch flush, downstream back-pressure).     Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module decode_controller
  import rv32i_pkg::*;
#(
  parameter int LOAD_USE_STALL = 1,
  parameter int FLUSH_CYCLES   = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        decode_enable,
  input  logic [31:0] instr,
  input  logic        branch_taken,
  input  logic        execute_stall_external,
  output logic        fetch_stall_external,
  output logic        execute_enable,
  output logic        decode_stall_control,
  output logic        decode_flush_control
);

  localparam logic [2:0] HAZ_RELOAD   = 3'(LOAD_USE_STALL - 1);
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  decode_state_t state_q, state_d;
  logic [2:0]    stall_cnt_q, stall_cnt_d;
  logic          ex_is_load_q, ex_is_load_d;
  logic [4:0]    ex_rd_q, ex_rd_d;

  logic          uses_rs1;
  logic          uses_rs2;
  logic          hazard_raw;
  logic          hazard;
  logic          issue;
  logic          unused_uses;

  hazard_detect u_hazard_detect (
    .instr      (instr),
    .ex_is_load (ex_is_load_q),
    .ex_rd      (ex_rd_q),
    .uses_rs1   (uses_rs1),
    .uses_rs2   (uses_rs2),
    .hazard     (hazard_raw)
  );

  assign unused_uses = uses_rs1 ^ uses_rs2;
  assign hazard      = decode_enable && hazard_raw;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      stall_cnt_q  <= 3'd0;
      ex_is_load_q <= 1'b0;
      ex_rd_q      <= 5'd0;
    end else begin
      state_q      <= state_d;
      stall_cnt_q  <= stall_cnt_d;
      ex_is_load_q <= ex_is_load_d;
      ex_rd_q      <= ex_rd_d;
    end
  end

  always_comb begin
    state_d              = state_q;
    stall_cnt_d          = stall_cnt_q;
    ex_is_load_d         = ex_is_load_q;
    ex_rd_d              = ex_rd_q;
    issue                = 1'b0;
    fetch_stall_external = 1'b0;
    decode_stall_control = 1'b0;
    decode_flush_control = 1'b0;

    if (branch_taken) begin
      decode_flush_control = 1'b1;
      ex_is_load_d         = 1'b0;
      stall_cnt_d          = FLUSH_RELOAD;
      state_d              = FLUSH;
    end else if (state_q == IDLE) begin
      if (decode_enable) begin
        state_d = DECODE;
      end
    end else if (execute_stall_external) begin
      fetch_stall_external = 1'b1;
      decode_stall_control = 1'b1;
    end else begin
      case (state_q)
        DECODE: begin
          if (hazard) begin
            fetch_stall_external = 1'b1;
            decode_flush_control = 1'b1;
            stall_cnt_d          = HAZ_RELOAD;
            state_d              = HAZARD;
          end else if (decode_enable) begin
            issue = 1'b1;
          end else begin
            ex_is_load_d = 1'b0;
            state_d      = IDLE;
          end
        end
        HAZARD: begin
          // The detecting cycle is the first bubble; the count-zero cycle
          // releases the held instruction so exactly LOAD_USE_STALL bubbles occur.
          if (stall_cnt_q != 3'd0) begin
            fetch_stall_external = 1'b1;
            decode_flush_control = 1'b1;
            stall_cnt_d          = stall_cnt_q - 3'd1;
          end else begin
            ex_is_load_d = 1'b0;
            issue        = decode_enable;
            state_d      = DECODE;
          end
        end
        FLUSH: begin
          decode_flush_control = 1'b1;
          if (stall_cnt_q == 3'd0) begin
            state_d = decode_enable ? DECODE : IDLE;
          end else begin
            stall_cnt_d = stall_cnt_q - 3'd1;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    if (issue) begin
      ex_is_load_d = (instr[6:0] == OP_LOAD);
      ex_rd_d      = instr[11:7];
    end
  end

  assign execute_enable = issue;

endmodule

`default_nettype wire

// File: tb/tb_decode_controller.sv
// ---------------------------------------------------------------------------
// tb_decode_controller : directed vector tables for decode_controller with
//                        LOAD_USE_STALL=1 and =3, plus async reset case. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_decode_controller;

  localparam logic [31:0] I_ADDI  = 32'h00500093; // addi x1,x0,5
  localparam logic [31:0] I_LW5   = 32'h00012283; // lw   x5,0(x2)
  localparam logic [31:0] I_ADD6  = 32'h00328333; // add  x6,x5,x3
  localparam logic [31:0] I_LW0   = 32'h00012003; // lw   x0,0(x2)
  localparam logic [31:0] I_ADD00 = 32'h00000333; // add  x6,x0,x0
  localparam logic [31:0] I_LUI5  = 32'h123452B7; // lui  x5,0x12345
  localparam logic [31:0] I_ADD7  = 32'h005083B3; // add  x7,x1,x5
  localparam logic [31:0] I_NOP   = 32'h00000013; // addi x0,x0,0

  // expected output nibble order: {fetch_stall, execute_enable, decode_stall, decode_flush}
  typedef struct {
    logic        de;
    logic [31:0] instr;
    logic        bt;
    logic        es;
    logic [3:0]  exp;
  } vec_t;

  logic        clk;
  logic        reset_n;
  logic        decode_enable;
  logic [31:0] instr;
  logic        branch_taken;
  logic        execute_stall_external;

  logic fs1, ee1, ds1, fl1;
  logic fs3, ee3, ds3, fl3;
  logic [3:0] out1, out3;

  int n_vec;
  int n_fail;

  vec_t tv1[$];
  vec_t tv3[$];

  assign out1 = {fs1, ee1, ds1, fl1};
  assign out3 = {fs3, ee3, ds3, fl3};

  decode_controller #(.LOAD_USE_STALL(1), .FLUSH_CYCLES(2)) dut1 (
    .clk                    (clk),
    .reset_n                (reset_n),
    .decode_enable          (decode_enable),
    .instr                  (instr),
    .branch_taken           (branch_taken),
    .execute_stall_external (execute_stall_external),
    .fetch_stall_external   (fs1),
    .execute_enable         (ee1),
    .decode_stall_control   (ds1),
    .decode_flush_control   (fl1)
  );

  decode_controller #(.LOAD_USE_STALL(3), .FLUSH_CYCLES(2)) dut3 (
    .clk                    (clk),
    .reset_n                (reset_n),
    .decode_enable          (decode_enable),
    .instr                  (instr),
    .branch_taken           (branch_taken),
    .execute_stall_external (execute_stall_external),
    .fetch_stall_external   (fs3),
    .execute_enable         (ee3),
    .decode_stall_control   (ds3),
    .decode_flush_control   (fl3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(input logic de, input logic [31:0] ins,
                              input logic bt, input logic es, input logic [3:0] exp);
    vec_t v;
    v.de = de; v.instr = ins; v.bt = bt; v.es = es; v.exp = exp;
    return v;
  endfunction

  task automatic chk(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b want %b (fs,ee,ds,fl)", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    decode_enable          = v.de;
    instr                  = v.instr;
    branch_taken           = v.bt;
    execute_stall_external = v.es;
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(mk(1'b0, I_NOP, 1'b0, 1'b0, 4'b0000));
    repeat (2) @(posedge clk);
    #1;
    chk("reset_dut1", out1, 4'b0000);
    chk("reset_dut3", out3, 4'b0000);
    reset_n = 1'b1;
  endtask

  initial begin
    n_vec  = 0;
    n_fail = 0;

    // LOAD_USE_STALL=1 main sequence
    tv1.push_back(mk(1, I_ADDI,  0, 0, 4'b0000)); // 0  IDLE -> DECODE
    tv1.push_back(mk(1, I_ADDI,  0, 0, 4'b0100)); // 1  issue
    tv1.push_back(mk(1, I_LW5,   0, 0, 4'b0100)); // 2  load x5 issues
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b1001)); // 3  load-use bubble
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0100)); // 4  held add issues
    tv1.push_back(mk(1, I_LW0,   0, 0, 4'b0100)); // 5  load x0
    tv1.push_back(mk(1, I_ADD00, 0, 0, 4'b0100)); // 6  x0 source: no stall
    tv1.push_back(mk(1, I_LW5,   0, 0, 4'b0100)); // 7
    tv1.push_back(mk(1, I_LUI5,  0, 0, 4'b0100)); // 8  lui has no sources
    tv1.push_back(mk(1, I_LW5,   0, 0, 4'b0100)); // 9
    tv1.push_back(mk(1, I_ADD7,  0, 0, 4'b1001)); // 10 hazard via rs2
    tv1.push_back(mk(1, I_ADD7,  0, 0, 4'b0100)); // 11
    tv1.push_back(mk(0, I_NOP,   0, 0, 4'b0000)); // 12 DECODE -> IDLE
    tv1.push_back(mk(0, I_NOP,   0, 0, 4'b0000)); // 13
    tv1.push_back(mk(1, I_NOP,   0, 0, 4'b0000)); // 14 IDLE -> DECODE
    tv1.push_back(mk(1, I_NOP,   1, 0, 4'b0001)); // 15 branch
    tv1.push_back(mk(1, I_NOP,   0, 0, 4'b0001)); // 16 flush slot 1
    tv1.push_back(mk(1, I_NOP,   0, 0, 4'b0001)); // 17 flush slot 2
    tv1.push_back(mk(1, I_NOP,   0, 0, 4'b0100)); // 18 resume issue
    tv1.push_back(mk(1, I_LW5,   0, 0, 4'b0100)); // 19
    tv1.push_back(mk(1, I_ADD6,  0, 1, 4'b1010)); // 20 exec stall beats hazard
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b1001)); // 21 hazard
    tv1.push_back(mk(1, I_ADD6,  1, 0, 4'b0001)); // 22 branch mid-HAZARD
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0001)); // 23
    tv1.push_back(mk(0, I_ADD6,  0, 0, 4'b0001)); // 24 FLUSH -> IDLE
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0000)); // 25 IDLE
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0100)); // 26 abandoned load gone
    tv1.push_back(mk(1, I_ADD6,  0, 1, 4'b1010)); // 27 exec stall
    tv1.push_back(mk(1, I_ADD6,  1, 1, 4'b0001)); // 28 branch beats stall
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0001)); // 29
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0001)); // 30
    tv1.push_back(mk(1, I_ADD6,  0, 0, 4'b0100)); // 31

    // LOAD_USE_STALL=3: three bubbles, then frozen countdown under exec stall
    tv3.push_back(mk(1, I_ADDI,  0, 0, 4'b0000));
    tv3.push_back(mk(1, I_ADDI,  0, 0, 4'b0100));
    tv3.push_back(mk(1, I_LW5,   0, 0, 4'b0100));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b0100));
    tv3.push_back(mk(1, I_NOP,   0, 0, 4'b0100));
    tv3.push_back(mk(1, I_LW5,   0, 0, 4'b0100));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    for (int k = 0; k < 4; k++) tv3.push_back(mk(1, I_ADD6, 0, 1, 4'b1010));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b1001));
    tv3.push_back(mk(1, I_ADD6,  0, 0, 4'b0100));

    do_reset();
    for (int i = 0; i < tv1.size(); i++) begin
      drive(tv1[i]);
      @(negedge clk);
      chk($sformatf("dut1_vec%0d", i), out1, tv1[i].exp);
      @(posedge clk);
      #1;
    end

    // asynchronous reset while flushing
    drive(mk(1, I_NOP, 1, 0, 4'b0000));
    @(posedge clk);
    #1;
    branch_taken = 1'b0;
    #1;
    chk("dut1_in_flush", out1, 4'b0001);
    reset_n = 1'b0;
    #1;
    chk("dut1_async_reset", out1, 4'b0000);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    @(negedge clk);
    chk("dut1_idle_after_reset", out1, 4'b0000);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("dut1_issue_after_reset", out1, 4'b0100);
    @(posedge clk);
    #1;

    do_reset();
    for (int i = 0; i < tv3.size(); i++) begin
      drive(tv3[i]);
      @(negedge clk);
      chk($sformatf("dut3_vec%0d", i), out3, tv3[i].exp);
      @(posedge clk);
      #1;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
